bkg_scroll_fetch: RTL and testbench
===================================

Name: bkg_scroll_fetch

Overview:
- Pixel-fetch stage directly upstream and downstream of the background RAM (160x160, 24-bit RGB, 15-bit address).
- Maps the VGA beam position (DrawX/DrawY) to a background read address, with 4x upscale and vertical wrap-around scrolling.
- Re-aligns the 1-cycle RAM read data with the pipelined blank signal.
- Drives background RGB to the colour mapper; owns the per-frame scroll-position accumulator used for the Doodle Jump parallax.

Parameters:
- IMG_W, 160: background width in pixels.
- IMG_H, 160: background height in pixels; vertical wrap modulus.
- SCALE_SHIFT, 2: log2 of the upscale factor (screen pixel to source pixel).
- ADDR_W, 15: RAM address width.

Ports:
- Clk  in  1  system clock, all state on posedge.
- Reset  in  1  asynchronous, active-low reset.
- DrawX  in  10  beam x, 0..639.
- DrawY  in  10  beam y, 0..479.
- blank  in  1  1 = active video, 0 = blanking.
- frame_start  in  1  single-cycle pulse once per frame, during vertical blanking.
- scroll_en  in  1  enables accumulation on frame_start.
- scroll_step  in  8  Q4.4 pixels per frame added to the scroll position.
- scroll_load  in  1  load scroll position.
- scroll_load_val  in  8  integer row to load, 0..159 (values of 160 or more are clamped to 159).
- fade_level  in  2  brightness shift; used only with BKG_FADE_EN.
- ram_data  in  24  RAM read data {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after the address.
- read_address  out  15  RAM read address.
- Red  out  8  background red.
- Green  out  8  background green.
- Blue  out  8  background blue.
- pixel_valid  out  1  RGB corresponds to an active-video pixel.
- scroll_y  out  8  current integer scroll row, 0..159.

Behaviour:
- Reset (async assert, sync release): clears read_address, Red/Green/Blue, pixel_valid, scroll_y, the 12-bit accumulator and all pipeline registers to 0.
  - Reset mid-frame flushes the pipeline; output stays 0 until 3 cycles after release.
- Scroll accumulator (acc, 12-bit Q8.4, range 0..2559):
  - scroll_load=1: acc <= {scroll_load_val, 4'b0}. Load has priority over a simultaneous frame_start.
  - Otherwise, frame_start=1 and scroll_en=1: sum = acc + scroll_step. If sum >= 2560, acc <= sum - 2560; else acc <= sum. A single subtraction suffices because the maximum sum is 2814.
  - scroll_y = acc[11:4]. It changes only on load or frame_start, so it is stable across active video (no tearing).
- Address stage (cycle N inputs, registered at edge N+1):
  - sx = DrawX >> SCALE_SHIFT (0..159).
  - ry = (DrawY >> SCALE_SHIFT) + scroll_y (0..278); sy = ry >= IMG_H ? ry - IMG_H : ry.
  - read_address <= sy*IMG_W + sx. IMG_W=160 is computed as (sy<<7)+(sy<<5); the maximum 25599 fits ADDR_W.
  - When blank=0, read_address holds its previous value (saves RAM toggling). The blank delay line still advances.
- Pipeline:
  - blank is delayed 3 stages: b1, b2, b3.
  - ram_data arrives at N+2 and is registered into Red/Green/Blue at edge N+3.
  - pixel_valid = b3.
  - If b3 = 0, RGB = 0.
  - Total latency from DrawX/DrawY to RGB is exactly 3 cycles. The bench checks this against a model.
- DrawX >= 640 or DrawY >= 480 occur only with blank=0; no address clamping is required beyond that.

Optional Feature:
- BKG_FADE_EN defined:
  - fade_level is sampled into a register on frame_start (and on load).
  - At the output register, each channel = ram channel >> fade_reg (0..3), e.g. 0xFF becomes 0x3F at level 2.
  - Reset clears fade_reg to 0.
- BKG_FADE_EN undefined: fade_level is ignored and no fade register exists; RGB equals ram_data unmodified.

Test Plan:
- Reset: hold Reset=0 for 5 cycles with random inputs -> read_address=0, RGB=0, pixel_valid=0, scroll_y=0. Release mid-line -> first nonzero RGB no earlier than 3 cycles later.
- Static fetch: scroll_y=0, blank=1, DrawX=100, DrawY=40 -> read_address=1625 (10*160+25) after 1 edge. A RAM model returning 0x12AB34 -> Red=0x12, Green=0xAB, Blue=0x34, pixel_valid=1 after 3 edges.
- Fractional scroll: scroll_en=1, scroll_step=0x18 (1.5), 3 frame_start pulses -> acc=72 (4.5), scroll_y=4. Then DrawY=0, DrawX=0 -> read_address=640.
- Vertical wrap: scroll_load_val=159, DrawY=8 (row 2) -> sy=1, DrawX=0 -> read_address=160. Then step=0x18 twice -> 159 -> 160.5 wraps to 0.5 -> 2.0, scroll_y=2.
- Priority and blanking: scroll_load=1 (val 7) together with frame_start and step=0xFF -> scroll_y=7. blank=0 for one cycle -> RGB=0 and pixel_valid=0 exactly 3 cycles later, and read_address unchanged.
- BKG_FADE_EN: fade_level=2 latched on frame_start, ram_data=0xFF80FF -> RGB = 0x3F, 0x20, 0x3F. Without the macro, same stimulus -> 0xFF, 0x80, 0xFF.

Source files
------------

// File: rtl/bkg_scroll_fetch.sv
// Background pixel fetch: beam position to RAM address with 4x upscale and wrap-around vertical scroll,
// plus 3-cycle re-alignment of RAM data with blank. Define BKG_FADE_EN to enable the per-frame brightness fade.
module bkg_scroll_fetch #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic              scroll_en,
    input  logic [7:0]        scroll_step,
    input  logic              scroll_load,
    input  logic [7:0]        scroll_load_val,
    input  logic [1:0]        fade_level,
    input  logic [23:0]       ram_data,
    output logic [ADDR_W-1:0] read_address,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              pixel_valid,
    output logic [7:0]        scroll_y
);

    localparam logic [9:0]  IMG_H_R = 10'(IMG_H);
    localparam logic [12:0] ACC_MOD = 13'(IMG_H * 16);
    localparam logic [7:0]  ROW_MAX = 8'(IMG_H - 1);

    logic [11:0]       acc;
    logic [7:0]        load_row;
    logic [9:0]        sx;
    logic [9:0]        ry;
    logic [9:0]        sy;
    logic [ADDR_W-1:0] addr_p0;
    logic              blank_p1;
    logic              blank_p2;
    logic              blank_p3;
    logic [23:0]       rgb_p2;
    logic [23:0]       rgb_p3;

    // Maximum sum is 2559 + 255, so one conditional subtraction covers the wrap.
    function automatic logic [11:0] acc_wrap(input logic [12:0] sum);
        if (sum >= ACC_MOD)
            return 12'(sum - ACC_MOD);
        return sum[11:0];
    endfunction

    function automatic logic [9:0] row_wrap(input logic [9:0] row);
        return (row >= IMG_H_R) ? row - IMG_H_R : row;
    endfunction

    function automatic logic [ADDR_W-1:0] row_base(input logic [9:0] row);
        if (IMG_W == 160)
            return (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5);
        return ADDR_W'(row) * ADDR_W'(IMG_W);
    endfunction

    assign load_row = (scroll_load_val > ROW_MAX) ? ROW_MAX : scroll_load_val;
    assign scroll_y = acc[11:4];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            acc <= '0;
        else if (scroll_load)
            acc <= {load_row, 4'b0000};
        else if (frame_start && scroll_en)
            acc <= acc_wrap({1'b0, acc} + {5'b00000, scroll_step});
    end

    always_comb begin
        sx      = DrawX >> SCALE_SHIFT;
        ry      = (DrawY >> SCALE_SHIFT) + {2'b00, scroll_y};
        sy      = row_wrap(ry);
        addr_p0 = row_base(sy) + ADDR_W'(sx);
    end

`ifdef BKG_FADE_EN
    logic [1:0] fade_reg;

    function automatic logic [23:0] fade_px(input logic [23:0] px, input logic [1:0] sh);
        return {px[23:16] >> sh, px[15:8] >> sh, px[7:0] >> sh};
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            fade_reg <= 2'd0;
        else if (scroll_load || frame_start)
            fade_reg <= fade_level;
    end

    assign rgb_p2 = fade_px(ram_data, fade_reg);
`else
    logic unused_fade;
    assign unused_fade = ^fade_level;
    assign rgb_p2      = ram_data;
`endif

    // Stage 1: address register (held during blanking) and blank delay.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            read_address <= '0;
            blank_p1     <= 1'b0;
        end else begin
            if (blank)
                read_address <= addr_p0;
            blank_p1 <= blank;
        end
    end

    // Stage 2: RAM is reading; only blank needs carrying.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            blank_p2 <= 1'b0;
        else
            blank_p2 <= blank_p1;
    end

    // Stage 3: RAM data captured alongside its blank; blanked pixels are forced black.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rgb_p3   <= '0;
            blank_p3 <= 1'b0;
        end else begin
            rgb_p3   <= blank_p2 ? rgb_p2 : 24'h000000;
            blank_p3 <= blank_p2;
        end
    end

    assign Red         = rgb_p3[23:16];
    assign Green       = rgb_p3[15:8];
    assign Blue        = rgb_p3[7:0];
    assign pixel_valid = blank_p3;

endmodule

// File: tb/tb_bkg_scroll_fetch.sv
// Randomized self-checking bench for bkg_scroll_fetch against a frame-level scroll/address model and a RAM model.
module tb_bkg_scroll_fetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_start = 1'b0;
    logic        scroll_en = 1'b0;
    logic [7:0]  scroll_step = '0;
    logic        scroll_load = 1'b0;
    logic [7:0]  scroll_load_val = '0;
    logic [1:0]  fade_level = '0;
    logic [23:0] ram_data = '0;
    logic [14:0] read_address;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        pixel_valid;
    logic [7:0]  scroll_y;

    bit          ovr = 1'b0;
    logic [23:0] ovr_val = '0;

    int          n_checks = 0;
    int          n_fail = 0;

    int          m_acc = 0;
    int          m_fade = 0;
    int          m_addr = 0;
    bit          bh1, bh2, bh3;
    logic [23:0] wh1, wh2, wh3;

    bkg_scroll_fetch dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .blank          (blank),
        .frame_start    (frame_start),
        .scroll_en      (scroll_en),
        .scroll_step    (scroll_step),
        .scroll_load    (scroll_load),
        .scroll_load_val(scroll_load_val),
        .fade_level     (fade_level),
        .ram_data       (ram_data),
        .read_address   (read_address),
        .Red            (Red),
        .Green          (Green),
        .Blue           (Blue),
        .pixel_valid    (pixel_valid),
        .scroll_y       (scroll_y)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] ram_word(input logic [14:0] a);
        return {a[7:0] ^ 8'hA5, a[14:7], a[7:0] + 8'h11};
    endfunction

    // Synchronous background RAM: data valid one cycle after the address.
    always @(posedge Clk)
        ram_data <= ovr ? ovr_val : ram_word(read_address);

    function automatic logic [23:0] shade(input logic [23:0] w, input int f);
        int d;
        d = 1 << f;
        return {8'(int'(w[23:16]) / d), 8'(int'(w[15:8]) / d), 8'(int'(w[7:0]) / d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_fade = 0; m_addr = 0;
        bh1 = 0; bh2 = 0; bh3 = 0;
        wh1 = '0; wh2 = '0; wh3 = '0;
    endtask

    // One clock: predict from the current inputs, advance the model, then compare all outputs.
    task automatic tick();
        int          row, pa, lv;
        logic [23:0] w, e;
        row = ((int'(DrawY) >> 2) + (m_acc >> 4)) % 160;
        pa  = row * 160 + (int'(DrawX) >> 2);
        w   = ovr ? ovr_val : ram_word(15'(pa));
        @(posedge Clk);
        e   = bh2 ? shade(wh2, m_fade) : 24'h000000;
        bh3 = bh2; wh3 = wh2;
        bh2 = bh1; wh2 = wh1;
        bh1 = blank; wh1 = w;
        if (blank)
            m_addr = pa;
        lv = (int'(scroll_load_val) > 159) ? 159 : int'(scroll_load_val);
        if (scroll_load)
            m_acc = lv * 16;
        else if (frame_start && scroll_en)
            m_acc = (m_acc + int'(scroll_step)) % 2560;
`ifdef BKG_FADE_EN
        if (scroll_load || frame_start)
            m_fade = int'(fade_level);
`endif
        #1;
        chk("addr", 32'(read_address), m_addr);
        chk("red", 32'(Red), 32'(e[23:16]));
        chk("green", 32'(Green), 32'(e[15:8]));
        chk("blue", 32'(Blue), 32'(e[7:0]));
        chk("valid", 32'(pixel_valid), 32'(bh3));
        chk("scroll_y", 32'(scroll_y), m_acc >> 4);
    endtask

    task automatic quiet();
        blank = 0; frame_start = 0; scroll_load = 0;
    endtask

    task automatic idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_frame();
        frame_start = 1; tick();
        frame_start = 0; tick();
    endtask

    task automatic load_row(input logic [7:0] v);
        quiet();
        scroll_load = 1; scroll_load_val = v; tick();
        scroll_load = 0;
    endtask

    initial begin
        logic [23:0] exp_fade;

        // Reset held with random inputs: everything stays at zero.
        Reset = 0;
        for (int i = 0; i < 5; i++) begin
            DrawX = 10'($urandom); DrawY = 10'($urandom);
            blank = 1'($urandom); frame_start = 1'($urandom); scroll_en = 1'($urandom);
            scroll_step = 8'($urandom); scroll_load = 1'($urandom);
            scroll_load_val = 8'($urandom); fade_level = 2'($urandom);
            @(posedge Clk); #1;
            chk("rst_addr", 32'(read_address), 0);
            chk("rst_rgb", 32'({Red, Green, Blue}), 0);
            chk("rst_valid", 32'(pixel_valid), 0);
            chk("rst_scroll", 32'(scroll_y), 0);
        end

        // Release mid-line with active video already running.
        model_reset();
        scroll_load = 0; frame_start = 0; scroll_en = 0; fade_level = 0;
        blank = 1; DrawY = 10'd200; DrawX = 10'd320;
        Reset = 1;
        for (int i = 0; i < 6; i++) begin
            DrawX = 10'(320 + i);
            tick();
            if (i < 2)
                chk("rel_early_rgb", 32'({Red, Green, Blue}), 0);
        end

        // Static fetch with a constant RAM word.
        idle(3);
        ovr = 1; ovr_val = 24'h12AB34;
        load_row(8'd0);
        idle(3);
        blank = 1; DrawX = 10'd100; DrawY = 10'd40;
        tick();
        chk("static_addr", 32'(read_address), 1625);
        tick(); tick();
        chk("static_red", 32'(Red), 32'h12);
        chk("static_green", 32'(Green), 32'hAB);
        chk("static_blue", 32'(Blue), 32'h34);
        chk("static_valid", 32'(pixel_valid), 1);

        // Fractional scroll: three steps of 1.5 rows.
        load_row(8'd0);
        scroll_en = 1; scroll_step = 8'h18;
        for (int i = 0; i < 3; i++) pulse_frame();
        chk("frac_scroll", 32'(scroll_y), 4);
        blank = 1; DrawX = 10'd0; DrawY = 10'd0;
        tick();
        chk("frac_addr", 32'(read_address), 640);

        // Vertical wrap of both the address and the accumulator.
        load_row(8'd159);
        blank = 1; DrawX = 10'd0; DrawY = 10'd8;
        tick();
        chk("wrap_addr", 32'(read_address), 160);
        quiet();
        pulse_frame(); pulse_frame();
        chk("wrap_scroll", 32'(scroll_y), 2);

        // Load beats a simultaneous frame step; out-of-range load clamps.
        quiet();
        scroll_load = 1; scroll_load_val = 8'd7; frame_start = 1; scroll_en = 1; scroll_step = 8'hFF;
        tick();
        chk("prio_scroll", 32'(scroll_y), 7);
        load_row(8'd200);
        chk("clamp_scroll", 32'(scroll_y), 159);
        load_row(8'd7);

        // One blanked cycle: address holds, output blanks exactly 3 cycles later.
        idle(3);
        ovr = 0;
        blank = 1; DrawX = 10'd200; DrawY = 10'd100;
        tick(); tick(); tick();
        chk("pre_blank_addr", 32'(read_address), 5170);
        blank = 0; DrawX = 10'd300; DrawY = 10'd300;
        tick();
        chk("hold_addr", 32'(read_address), 5170);
        blank = 1; DrawX = 10'd204; DrawY = 10'd100;
        tick();
        chk("blank_n2_valid", 32'(pixel_valid), 1);
        tick();
        chk("blank_n3_valid", 32'(pixel_valid), 0);
        chk("blank_n3_rgb", 32'({Red, Green, Blue}), 0);
        tick();
        chk("blank_n4_valid", 32'(pixel_valid), 1);

        // Fade level latched on frame_start.
        idle(3);
        ovr = 1; ovr_val = 24'hFF80FF;
        scroll_en = 0; fade_level = 2'd2; frame_start = 1;
        tick();
        frame_start = 0; fade_level = 2'd0;
        blank = 1; DrawX = 10'd8; DrawY = 10'd8;
        tick(); tick(); tick();
`ifdef BKG_FADE_EN
        exp_fade = 24'h3F203F;
`else
        exp_fade = 24'hFF80FF;
`endif
        chk("fade_red", 32'(Red), 32'(exp_fade[23:16]));
        chk("fade_green", 32'(Green), 32'(exp_fade[15:8]));
        chk("fade_blue", 32'(Blue), 32'(exp_fade[7:0]));
        idle(3);
        ovr = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            blank = ($urandom_range(0, 15) != 0);
            if (blank) begin
                DrawX = 10'($urandom_range(0, 639));
                DrawY = 10'($urandom_range(0, 479));
            end else begin
                DrawX = 10'($urandom);
                DrawY = 10'($urandom);
            end
            frame_start     = ($urandom_range(0, 40) == 0);
            scroll_load     = ($urandom_range(0, 150) == 0);
            scroll_load_val = 8'($urandom);
            scroll_en       = 1'($urandom);
            scroll_step     = 8'($urandom);
            fade_level      = 2'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
